// File: rtl/axi_ic_pkg.sv
// Shared types and width helpers for the AXI interconnect write arbiter.
package axi_ic_pkg;

  localparam int unsigned MAX_SW = 8;

  typedef enum logic [1:0] {
    AW_IDLE = 2'd0,
    AW_ADDR = 2'd1,
    AW_DATA = 2'd2
  } aw_state_e;

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_ALLOW = 2'd1
  } b_state_e;

  // Slave index is stored zero-extended so the struct stays parameter-free.
  typedef struct packed {
    logic              valid;
    logic [MAX_SW-1:0] slave;
  } id_entry_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned mw(input int unsigned m);
    return idx_width(m);
  endfunction

  function automatic int unsigned sw(input int unsigned s);
    return idx_width(s);
  endfunction

  function automatic int unsigned iw(input int unsigned n);
    return idx_width(n);
  endfunction

endpackage

// File: rtl/addr_decode.sv
// Maps an AW address onto the index of the slave whose address slice contains it.
module addr_decode #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SW         = 1,
  parameter logic [31:0] SLICE_SIZE = 32'h0001_0000
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [SW-1:0]         sel
);

  always_comb begin
    sel = SW'(addr / ADDR_WIDTH'(SLICE_SIZE));
  end

endmodule

// File: rtl/write_id_table.sv
// Outstanding-write table: one entry per (master, ID) holding a valid bit and target slave.
module write_id_table
  import axi_ic_pkg::*;
#(
  parameter int unsigned M  = 2,
  parameter int unsigned N  = 2,
  parameter int unsigned MW = 1,
  parameter int unsigned IW = 1,
  parameter int unsigned SW = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          set_en,
  input  logic [MW-1:0] set_m,
  input  logic [IW-1:0] set_t,
  input  logic [SW-1:0] set_slave,
  input  logic          clear_en,
  input  logic [MW-1:0] clear_m,
  input  logic [IW-1:0] clear_t,
  input  logic [MW-1:0] aw_m,
  input  logic [IW-1:0] aw_t,
  output logic          aw_busy,
  input  logic [MW-1:0] b_m,
  input  logic [IW-1:0] b_t,
  output id_entry_t     b_entry
);

  id_entry_t tbl_q [M][N];
  id_entry_t tbl_d [M][N];

  function automatic logic in_range(input logic [MW-1:0] mi, input logic [IW-1:0] ti);
    return (32'(mi) < M) && (32'(ti) < N);
  endfunction

  // A set needs an invalid entry and a clear a valid one, so both may fire in one cycle.
  always_comb begin
    tbl_d = tbl_q;
    if (set_en && in_range(set_m, set_t)) begin
      tbl_d[set_m][set_t] = '{valid: 1'b1, slave: MAX_SW'(set_slave)};
    end
    if (clear_en && in_range(clear_m, clear_t)) begin
      tbl_d[clear_m][clear_t] = '0;
    end
  end

  always_comb begin
    aw_busy = 1'b0;
    b_entry = '0;
    if (in_range(aw_m, aw_t)) aw_busy = tbl_q[aw_m][aw_t].valid;
    if (in_range(b_m, b_t))   b_entry = tbl_q[b_m][b_t];
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int unsigned i = 0; i < M; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          tbl_q[i][j] <= '0;
        end
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

endmodule

// File: rtl/write_arbiter.sv
// AXI write-path arbiter: round-robin AW/W over masters, round-robin B over slaves
// gated by the outstanding-write table.
module write_arbiter
  import axi_ic_pkg::*;
#(
  parameter int unsigned M                     = 2,
  parameter int unsigned S                     = 2,
  parameter int unsigned NUM_OUTSTANDING_TRANS = 2,
  parameter int unsigned ADDR_WIDTH            = 32,
  parameter logic [31:0] SLICE_SIZE            = 32'h0001_0000,
  localparam int unsigned MW = mw(M),
  localparam int unsigned SW = sw(S),
  localparam int unsigned IW = iw(NUM_OUTSTANDING_TRANS)
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [M-1:0]            AW_request_f,
  input  logic [M*ADDR_WIDTH-1:0] AW_addr_f,
  input  logic [M*IW-1:0]         AW_id_f,
  input  logic [S-1:0]            AW_finish_f,
  output logic [M-1:0]            AW_grant_f,
  output logic [M*SW-1:0]         AW_sel_f,
  input  logic [M-1:0]            W_last_f,
  output logic [M-1:0]            W_grant_f,
  output logic [M*SW-1:0]         W_sel_f,
  input  logic [S-1:0]            B_request_f,
  input  logic [S*(MW+IW)-1:0]    B_id_f,
  input  logic [S-1:0]            B_finish_f,
  output logic [S-1:0]            B_grant_f,
  output logic [S*MW-1:0]         B_sel_f
);

  function automatic logic [MW-1:0] next_m(input logic [MW-1:0] p);
    return (32'(p) + 1 >= M) ? '0 : p + MW'(1);
  endfunction

  function automatic logic [SW-1:0] next_s(input logic [SW-1:0] p);
    return (32'(p) + 1 >= S) ? '0 : p + SW'(1);
  endfunction

  logic [M*SW-1:0] aw_sel;

  for (genvar g = 0; g < M; g++) begin : g_dec
    addr_decode #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .SW        (SW),
      .SLICE_SIZE(SLICE_SIZE)
    ) u_dec (
      .addr(AW_addr_f[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .sel (aw_sel[g*SW +: SW])
    );
  end

  assign AW_sel_f = aw_sel;

  aw_state_e     aw_state_q, aw_state_d;
  logic [MW-1:0] aw_ptr_q, aw_ptr_d;
  logic [MW-1:0] aw_owner_q, aw_owner_d;
  logic [SW-1:0] aw_slave_q, aw_slave_d;

  b_state_e      b_state_q, b_state_d;
  logic [SW-1:0] b_ptr_q, b_ptr_d;
  logic [SW-1:0] b_slave_q, b_slave_d;
  logic [MW-1:0] b_master_q, b_master_d;
  logic [IW-1:0] b_trans_q, b_trans_d;

  logic [IW-1:0]    aw_cand_id;
  logic [SW-1:0]    aw_cand_sel;
  logic             aw_busy;
  logic             set_en;
  logic [MW+IW-1:0] b_cand;
  logic [MW-1:0]    b_cand_m;
  logic [IW-1:0]    b_cand_t;
  id_entry_t        b_entry;
  logic             b_match;
  logic             clear_en;

  assign aw_cand_id  = AW_id_f[aw_ptr_q*IW +: IW];
  assign aw_cand_sel = aw_sel[aw_ptr_q*SW +: SW];
  assign b_cand      = B_id_f[b_ptr_q*(MW+IW) +: (MW+IW)];
  assign b_cand_m    = b_cand[MW+IW-1 -: MW];
  assign b_cand_t    = b_cand[IW-1:0];

  write_id_table #(
    .M (M),
    .N (NUM_OUTSTANDING_TRANS),
    .MW(MW),
    .IW(IW),
    .SW(SW)
  ) u_table (
    .clk      (clk),
    .clr      (clr),
    .set_en   (set_en),
    .set_m    (aw_ptr_q),
    .set_t    (aw_cand_id),
    .set_slave(aw_cand_sel),
    .clear_en (clear_en),
    .clear_m  (b_master_q),
    .clear_t  (b_trans_q),
    .aw_m     (aw_ptr_q),
    .aw_t     (aw_cand_id),
    .aw_busy  (aw_busy),
    .b_m      (b_cand_m),
    .b_t      (b_cand_t),
    .b_entry  (b_entry)
  );

  // Only a response from the slave recorded for that (master, ID) may be routed back.
  assign b_match = B_request_f[b_ptr_q] && (32'(b_cand_m) < M) && b_entry.valid &&
                   (b_entry.slave == MAX_SW'(b_ptr_q));

  always_comb begin
    aw_state_d = aw_state_q;
    aw_ptr_d   = aw_ptr_q;
    aw_owner_d = aw_owner_q;
    aw_slave_d = aw_slave_q;
    set_en     = 1'b0;
    AW_grant_f = '0;
    W_grant_f  = '0;
    W_sel_f    = '0;
    case (aw_state_q)
      AW_IDLE: begin
        if (AW_request_f[aw_ptr_q] && !aw_busy) begin
          set_en     = 1'b1;
          aw_owner_d = aw_ptr_q;
          aw_slave_d = aw_cand_sel;
          aw_state_d = AW_ADDR;
        end else begin
          aw_ptr_d = next_m(aw_ptr_q);
        end
      end
      AW_ADDR: begin
        AW_grant_f[aw_owner_q] = 1'b1;
        if (AW_finish_f[aw_slave_q]) aw_state_d = AW_DATA;
      end
      AW_DATA: begin
        W_grant_f[aw_owner_q]            = 1'b1;
        W_sel_f[aw_owner_q*SW +: SW]     = aw_slave_q;
        if (W_last_f[aw_owner_q]) begin
          aw_state_d = AW_IDLE;
          aw_ptr_d   = next_m(aw_owner_q);
        end
      end
      default: aw_state_d = AW_IDLE;
    endcase
  end

  always_comb begin
    b_state_d  = b_state_q;
    b_ptr_d    = b_ptr_q;
    b_slave_d  = b_slave_q;
    b_master_d = b_master_q;
    b_trans_d  = b_trans_q;
    clear_en   = 1'b0;
    B_grant_f  = '0;
    B_sel_f    = '0;
    case (b_state_q)
      B_IDLE: begin
        if (b_match) begin
          b_slave_d  = b_ptr_q;
          b_master_d = b_cand_m;
          b_trans_d  = b_cand_t;
          b_state_d  = B_ALLOW;
        end else begin
          b_ptr_d = next_s(b_ptr_q);
        end
      end
      B_ALLOW: begin
        B_grant_f[b_slave_q]         = 1'b1;
        B_sel_f[b_slave_q*MW +: MW]  = b_master_q;
        if (B_finish_f[b_slave_q]) begin
          clear_en  = 1'b1;
          b_state_d = B_IDLE;
          b_ptr_d   = next_s(b_slave_q);
        end
      end
      default: b_state_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      aw_state_q <= AW_IDLE;
      aw_ptr_q   <= '0;
      aw_owner_q <= '0;
      aw_slave_q <= '0;
      b_state_q  <= B_IDLE;
      b_ptr_q    <= '0;
      b_slave_q  <= '0;
      b_master_q <= '0;
      b_trans_q  <= '0;
    end else begin
      aw_state_q <= aw_state_d;
      aw_ptr_q   <= aw_ptr_d;
      aw_owner_q <= aw_owner_d;
      aw_slave_q <= aw_slave_d;
      b_state_q  <= b_state_d;
      b_ptr_q    <= b_ptr_d;
      b_slave_q  <= b_slave_d;
      b_master_q <= b_master_d;
      b_trans_q  <= b_trans_d;
    end
  end

endmodule

// File: tb/tb_write_arbiter.sv
// Bench for write_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_write_arbiter;

  localparam int unsigned M     = 2;
  localparam int unsigned S     = 2;
  localparam int unsigned NT    = 2;
  localparam int unsigned AWD   = 32;
  localparam logic [31:0] SLICE = 32'h0001_0000;
  localparam int unsigned MW    = 1;
  localparam int unsigned SW    = 1;
  localparam int unsigned IW    = 1;

  logic                 clk = 1'b0;
  logic                 clr;
  logic [M-1:0]         AW_request_f;
  logic [M*AWD-1:0]     AW_addr_f;
  logic [M*IW-1:0]      AW_id_f;
  logic [S-1:0]         AW_finish_f;
  logic [M-1:0]         AW_grant_f;
  logic [M*SW-1:0]      AW_sel_f;
  logic [M-1:0]         W_last_f;
  logic [M-1:0]         W_grant_f;
  logic [M*SW-1:0]      W_sel_f;
  logic [S-1:0]         B_request_f;
  logic [S*(MW+IW)-1:0] B_id_f;
  logic [S-1:0]         B_finish_f;
  logic [S-1:0]         B_grant_f;
  logic [S*MW-1:0]      B_sel_f;

  write_arbiter #(
    .M                    (M),
    .S                    (S),
    .NUM_OUTSTANDING_TRANS(NT),
    .ADDR_WIDTH           (AWD),
    .SLICE_SIZE           (SLICE)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .AW_request_f(AW_request_f),
    .AW_addr_f   (AW_addr_f),
    .AW_id_f     (AW_id_f),
    .AW_finish_f (AW_finish_f),
    .AW_grant_f  (AW_grant_f),
    .AW_sel_f    (AW_sel_f),
    .W_last_f    (W_last_f),
    .W_grant_f   (W_grant_f),
    .W_sel_f     (W_sel_f),
    .B_request_f (B_request_f),
    .B_id_f      (B_id_f),
    .B_finish_f  (B_finish_f),
    .B_grant_f   (B_grant_f),
    .B_sel_f     (B_sel_f)
  );

  always #5 clk = ~clk;

  // Model: set of outstanding writes plus the two round-robin positions.
  bit          ref_valid [M][NT];
  int unsigned ref_slave [M][NT];
  int unsigned aw_ptr_ref, b_ptr_ref;
  bit          aw_hold, b_hold;
  int unsigned cur_slave;

  logic [31:0] m_addr [M];
  int unsigned m_id   [M];
  bit [M-1:0]  m_req;
  bit [S-1:0]  s_req;
  int unsigned s_m [S];
  int unsigned s_t [S];

  int unsigned n_pass, n_fail, n_total;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] oh(input int unsigned i);
    return 64'(1) << i;
  endfunction

  function automatic int unsigned sel_of(input logic [31:0] a);
    return (a / SLICE) % (1 << SW);
  endfunction

  task automatic drive();
    for (int i = 0; i < M; i++) begin
      AW_request_f[i]          = m_req[i];
      AW_addr_f[i*AWD +: AWD]  = m_addr[i];
      AW_id_f[i*IW +: IW]      = IW'(m_id[i]);
    end
    for (int j = 0; j < S; j++) begin
      B_request_f[j]              = s_req[j];
      B_id_f[j*(MW+IW) +: MW+IW]  = {MW'(s_m[j]), IW'(s_t[j])};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!aw_hold) aw_ptr_ref = (aw_ptr_ref + 1) % M;
    if (!b_hold)  b_ptr_ref  = (b_ptr_ref + 1) % S;
    @(negedge clk);
  endtask

  function automatic bit aw_elig(input int unsigned c);
    return m_req[c] && !ref_valid[c][m_id[c]];
  endfunction

  function automatic bit b_elig(input int unsigned j);
    return s_req[j] && (s_m[j] < M) && (s_t[j] < NT) &&
           ref_valid[s_m[j]][s_t[j]] && (ref_slave[s_m[j]][s_t[j]] == j);
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_aw_grant"}, AW_grant_f, '0);
    chk({tag, "_w_grant"},  W_grant_f,  '0);
    chk({tag, "_w_sel"},    W_sel_f,    '0);
    chk({tag, "_b_grant"},  B_grant_f,  '0);
    chk({tag, "_b_sel"},    B_sel_f,    '0);
  endtask

  // Presents m_req and carries the winner up to the start of its W burst.
  task automatic aw_start(output int w);
    int          k;
    logic [63:0] sel_exp;
    w = -1;
    k = 0;
    for (int d = 0; d < M; d++) begin
      int c;
      c = (aw_ptr_ref + d) % M;
      if (w < 0 && aw_elig(c)) begin
        w = c;
        k = d;
      end
    end
    drive();
    #1;
    sel_exp = '0;
    for (int i = 0; i < M; i++) sel_exp |= 64'(sel_of(m_addr[i])) << (i*SW);
    chk("aw_sel", AW_sel_f, sel_exp);
    if (w < 0) begin
      for (int i = 0; i < 2*M; i++) begin
        tick();
        chk("aw_blocked_grant", AW_grant_f, '0);
      end
      m_req = '0;
      drive();
      return;
    end
    aw_hold = 1'b1;
    for (int d = 0; d < k; d++) begin
      tick();
      chk("aw_wait_grant", AW_grant_f, '0);
    end
    tick();
    chk("aw_grant", AW_grant_f, oh(w));
    chk("aw_grant_no_w", W_grant_f, '0);
    cur_slave = sel_of(m_addr[w]);
    ref_valid[w][m_id[w]] = 1'b1;
    ref_slave[w][m_id[w]] = cur_slave;
    m_req = '0;
    drive();
    AW_finish_f = S'(oh((cur_slave + 1) % S));
    tick();
    AW_finish_f = '0;
    chk("aw_hold_other_finish", AW_grant_f, oh(w));
    AW_finish_f = S'(oh(cur_slave));
    tick();
    AW_finish_f = '0;
    chk("w_grant", W_grant_f, oh(w));
    chk("w_sel", W_sel_f, 64'(cur_slave) << (w*SW));
    chk("aw_grant_dropped", AW_grant_f, '0);
  endtask

  task automatic aw_end(input int w);
    int unsigned beats;
    beats = $urandom_range(0, 2);
    for (int i = 0; i < int'(beats); i++) begin
      W_last_f = M'(oh((w + 1) % M));
      tick();
      W_last_f = '0;
      chk("w_grant_held", W_grant_f, oh(w));
    end
    W_last_f = M'(oh(w));
    tick();
    W_last_f = '0;
    chk("w_done_grant", W_grant_f, '0);
    chk("w_done_sel", W_sel_f, '0);
    chk("w_done_aw", AW_grant_f, '0);
    aw_ptr_ref = (w + 1) % M;
    aw_hold = 1'b0;
  endtask

  task automatic b_round(output int w);
    int          k;
    int unsigned bm, bt;
    w = -1;
    k = 0;
    for (int d = 0; d < S; d++) begin
      int j;
      j = (b_ptr_ref + d) % S;
      if (w < 0 && b_elig(j)) begin
        w = j;
        k = d;
      end
    end
    drive();
    if (w < 0) begin
      for (int i = 0; i < 2*S; i++) begin
        tick();
        chk("b_reject_grant", B_grant_f, '0);
      end
      s_req = '0;
      drive();
      return;
    end
    b_hold = 1'b1;
    for (int d = 0; d < k; d++) begin
      tick();
      chk("b_wait_grant", B_grant_f, '0);
    end
    tick();
    bm = s_m[w];
    bt = s_t[w];
    chk("b_grant", B_grant_f, oh(w));
    chk("b_sel", B_sel_f, 64'(bm) << (w*MW));
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      B_finish_f = S'(oh((w + 1) % S));
      tick();
      B_finish_f = '0;
      chk("b_grant_held", B_grant_f, oh(w));
    end
    s_req[w]   = 1'b0;
    drive();
    B_finish_f = S'(oh(w));
    tick();
    B_finish_f = '0;
    chk("b_done_grant", B_grant_f, '0);
    chk("b_done_sel", B_sel_f, '0);
    ref_valid[bm][bt] = 1'b0;
    b_ptr_ref = (w + 1) % S;
    b_hold = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < M; i++)
      for (int t = 0; t < NT; t++) ref_valid[i][t] = 1'b0;
    aw_ptr_ref = 0;
    b_ptr_ref  = 0;
    aw_hold    = 1'b0;
    b_hold     = 1'b0;
  endtask

  initial begin
    int w, w2;
    n_pass = 0; n_fail = 0; n_total = 0;
    clr = 1'b0;
    m_req = '0; s_req = '0;
    for (int i = 0; i < M; i++) begin m_addr[i] = '0; m_id[i] = 0; end
    for (int j = 0; j < S; j++) begin s_m[j] = 0; s_t[j] = 0; end
    AW_finish_f = '0; W_last_f = '0; B_finish_f = '0;
    drive();
    model_reset();
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_aw_sel", AW_sel_f, '0);
    clr = 1'b1;

    // Both masters request with the pointer at 0: M0 first, then M1.
    m_addr[0] = 32'h0001_0004; m_id[0] = 1;
    m_addr[1] = 32'h0001_0000; m_id[1] = 0;
    m_req = 2'b11;
    aw_start(w);
    chk("rr_first_winner", 64'(w), 64'(0));
    aw_end(w);
    m_req = 2'b10;
    aw_start(w);
    chk("rr_second_winner", 64'(w), 64'(1));
    aw_end(w);

    // Response for M0 ID1 from slave 1.
    s_req = 2'b10; s_m[1] = 0; s_t[1] = 1;
    b_round(w);
    chk("b_single_slave", 64'(w), 64'(1));
    // Same response again: entry already cleared.
    s_req = 2'b10; s_m[1] = 0; s_t[1] = 1;
    b_round(w);

    // Wrong slave for M1 ID0, then the right one.
    s_req = 2'b01; s_m[0] = 1; s_t[0] = 0;
    b_round(w);
    s_req = 2'b10; s_m[1] = 1; s_t[1] = 0;
    b_round(w);
    chk("b_right_slave", 64'(w), 64'(1));

    // M0 reuses an outstanding ID; M1 is served meanwhile.
    m_addr[0] = 32'h0000_0010; m_id[0] = 0; m_req = 2'b01;
    aw_start(w); aw_end(w);
    m_addr[1] = 32'h0001_0020; m_id[1] = 1; m_req = 2'b11;
    aw_start(w);
    chk("busy_id_skipped", 64'(w), 64'(1));
    aw_end(w);
    s_req = 2'b01; s_m[0] = 0; s_t[0] = 0;
    b_round(w);
    m_req = 2'b01;
    aw_start(w);
    chk("freed_id_granted", 64'(w), 64'(0));
    aw_end(w);

    // Two valid responses at once are served one after the other.
    s_req = 2'b11; s_m[0] = 0; s_t[0] = 0; s_m[1] = 1; s_t[1] = 1;
    b_round(w);
    b_round(w2);
    chk("b_rr_both_served", 64'(w + w2), 64'(1));

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < M; i++) begin
          m_req[i]  = 1'($urandom_range(0, 1));
          m_addr[i] = ($urandom_range(0, 3) << 16) | ($urandom & 32'h0000_fffc);
          m_id[i]   = $urandom_range(0, NT-1);
        end
        aw_start(w);
        if (w >= 0) aw_end(w);
      end else begin
        for (int j = 0; j < S; j++) begin
          s_req[j] = 1'($urandom_range(0, 1));
          s_m[j]   = $urandom_range(0, M-1);
          s_t[j]   = $urandom_range(0, NT-1);
        end
        b_round(w);
        s_req = '0;
        drive();
      end
    end

    // Reset in the middle of a W burst.
    m_addr[0] = 32'h0001_0000; m_id[0] = 0; m_req = 2'b01;
    for (int i = 0; i < M; i++)
      for (int t = 0; t < NT; t++) ref_valid[i][t] = 1'b0;
    clr = 1'b0; #1; clr = 1'b1;
    model_reset();
    aw_start(w);
    clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("mid_reset");
    clr = 1'b1;
    model_reset();
    s_req = 2'b10; s_m[1] = 0; s_t[1] = 0;
    b_round(w);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
